// File: rtl/collision_scanner_pkg.sv
// Shared types and default geometry for the multi-enemy collision scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package collision_pkg;

  // Scanner control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default geometry in pixels; boxes are closed intervals [x, x+W] x [y, y+H].
  localparam int COORD_W_DEF     = 10;
  localparam int NUM_ENEMIES_DEF = 4;
  localparam int CAR_W_DEF       = 80;
  localparam int CAR_H_DEF       = 121;
  localparam int ENEMY_W_DEF     = 80;
  localparam int ENEMY_H_DEF     = 121;

endpackage

// File: rtl/collision_scanner_aabb_overlap.sv
// Axis-aligned box overlap test between the player car and one enemy, edges inclusive.
// Latency: purely combinational.
// Backpressure: none; the result follows the inputs.
module aabb_overlap #(
  parameter int COORD_W = 10,
  parameter int CAR_W   = 80,
  parameter int CAR_H   = 121,
  parameter int ENEMY_W = 80,
  parameter int ENEMY_H = 121
) (
  input  logic [COORD_W-1:0] car_x,
  input  logic [COORD_W-1:0] car_y,
  input  logic [COORD_W-1:0] enemy_x,
  input  logic [COORD_W-1:0] enemy_y,
  output logic               hit
);

  // One extra bit so right/bottom edges near the top of the coordinate range
  // cannot wrap around and alias to a small value.
  localparam int SW = COORD_W + 1;

  logic [SW-1:0] car_l, car_t, car_r, car_b;
  logic [SW-1:0] en_l, en_t, en_r, en_b;

  // Extend the box corners and compare all four separating-axis conditions.
  always_comb begin
    car_l = {1'b0, car_x};
    car_t = {1'b0, car_y};
    en_l  = {1'b0, enemy_x};
    en_t  = {1'b0, enemy_y};
    car_r = car_l + SW'(CAR_W);
    car_b = car_t + SW'(CAR_H);
    en_r  = en_l + SW'(ENEMY_W);
    en_b  = en_t + SW'(ENEMY_H);
    hit   = (car_l <= en_r) && (en_l <= car_r) &&
            (car_t <= en_b) && (en_t <= car_b);
  end

endmodule

// File: rtl/collision_scanner.sv
// Per-frame collision scan: snapshots car and enemy positions on start and tests one enemy per clock.
// Latency: start sampled in cycle T -> done pulse and new hit_mask/collision in cycle T+NUM_ENEMIES+1.
// Backpressure: none; start while busy is dropped. Optional hit_count port under COLLISION_COUNT_EN.
module collision_scanner
  import collision_pkg::*;
#(
  parameter int NUM_ENEMIES = NUM_ENEMIES_DEF,
  parameter int COORD_W     = COORD_W_DEF,
  parameter int CAR_W       = CAR_W_DEF,
  parameter int CAR_H       = CAR_H_DEF,
  parameter int ENEMY_W     = ENEMY_W_DEF,
  parameter int ENEMY_H     = ENEMY_H_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [COORD_W-1:0]             car_x,
  input  logic [COORD_W-1:0]             car_y,
  input  logic [NUM_ENEMIES*COORD_W-1:0] enemy_x,
  input  logic [NUM_ENEMIES*COORD_W-1:0] enemy_y,
  input  logic [NUM_ENEMIES-1:0]         enemy_valid,
  output logic                           busy,
  output logic                           done,
  output logic                           collision,
`ifdef COLLISION_COUNT_EN
  output logic [7:0]                     hit_count,
`endif
  output logic [NUM_ENEMIES-1:0]         hit_mask
);

  localparam int IDX_W = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;

  state_t                     state, state_nxt;
  logic [IDX_W-1:0]           idx;
  logic [COORD_W-1:0]         snap_car_x, snap_car_y;
  logic [NUM_ENEMIES*COORD_W-1:0] snap_ex, snap_ey;
  logic [NUM_ENEMIES-1:0]     snap_valid;
  logic [NUM_ENEMIES-1:0]     work_mask;
  logic [NUM_ENEMIES-1:0]     cur_mask;
  logic [COORD_W-1:0]         cur_ex, cur_ey;
  logic                       overlap;
  logic                       last_idx;

  // Select the snapshot entry for the enemy under test and fold its result in.
  always_comb begin
    cur_ex   = snap_ex[idx*COORD_W +: COORD_W];
    cur_ey   = snap_ey[idx*COORD_W +: COORD_W];
    last_idx = (idx == IDX_W'(NUM_ENEMIES - 1));
    cur_mask = work_mask | (NUM_ENEMIES'(overlap & snap_valid[idx]) << idx);
  end

  aabb_overlap #(
    .COORD_W (COORD_W),
    .CAR_W   (CAR_W),
    .CAR_H   (CAR_H),
    .ENEMY_W (ENEMY_W),
    .ENEMY_H (ENEMY_H)
  ) u_overlap (
    .car_x   (snap_car_x),
    .car_y   (snap_car_y),
    .enemy_x (cur_ex),
    .enemy_y (cur_ey),
    .hit     (overlap)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: one SCAN cycle per enemy, then a single DONE cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (last_idx) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Snapshot, scan index, working mask and result registers. Results load on
  // the final SCAN edge so they are already valid during the done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      snap_car_x <= '0;
      snap_car_y <= '0;
      snap_ex    <= '0;
      snap_ey    <= '0;
      snap_valid <= '0;
      work_mask  <= '0;
      hit_mask   <= '0;
      collision  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snap_car_x <= car_x;
            snap_car_y <= car_y;
            snap_ex    <= enemy_x;
            snap_ey    <= enemy_y;
            snap_valid <= enemy_valid;
            idx        <= '0;
            work_mask  <= '0;
          end
        end
        SCAN: begin
          work_mask <= cur_mask;
          if (last_idx) begin
            idx       <= '0;
            hit_mask  <= cur_mask;
            collision <= |cur_mask;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef COLLISION_COUNT_EN
  // Saturating count of frames whose result reported a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count <= 8'd0;
    end else if (state == SCAN && last_idx && (|cur_mask) && hit_count != 8'd255) begin
      hit_count <= hit_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_collision_scanner.sv
// Directed bench for collision_scanner with hand-computed expectations.
// Latency: frames expected to finish with done exactly NUM_ENEMIES+1 cycles after start.
// Backpressure: exercises dropped start while busy and reset during a scan.
module tb_collision_scanner;

  localparam int N  = 4;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] car_x, car_y;
  logic [N*CW-1:0] enemy_x, enemy_y;
  logic [N-1:0]  enemy_valid;
  logic          busy, done, collision;
  logic [N-1:0]  hit_mask;
`ifdef COLLISION_COUNT_EN
  logic [7:0]    hit_count;
`endif

  int errors = 0;
  int checks = 0;

  collision_scanner dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .car_x       (car_x),
    .car_y       (car_y),
    .enemy_x     (enemy_x),
    .enemy_y     (enemy_y),
    .enemy_valid (enemy_valid),
    .busy        (busy),
    .done        (done),
    .collision   (collision),
`ifdef COLLISION_COUNT_EN
    .hit_count   (hit_count),
`endif
    .hit_mask    (hit_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_enemy(input int i, input int x, input int y);
    enemy_x[i*CW +: CW] = CW'(x);
    enemy_y[i*CW +: CW] = CW'(y);
  endtask

  // Pulse start for one cycle, wait (bounded) for done, sample results in the
  // done cycle, then step one more cycle so the scanner is idle again.
  task automatic frame(output int lat, output logic [N-1:0] m, output logic c, output logic b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    m = hit_mask;
    c = collision;
    b = busy;
    @(negedge clk);
  endtask

  int         lat;
  logic [N-1:0] m;
  logic       c, b;
  int         seen_done;

  initial begin
    rst = 1'b1; start = 1'b0;
    car_x = '0; car_y = '0; enemy_x = '0; enemy_y = '0; enemy_valid = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_collision", 32'(collision), 0);
    check("reset_hit_mask", 32'(hit_mask), 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic hit on enemy 0.
    car_x = 100; car_y = 200;
    set_enemy(0, 150, 250); set_enemy(1, 500, 500); set_enemy(2, 500, 500); set_enemy(3, 500, 500);
    enemy_valid = 4'b0001;
    frame(lat, m, c, b);
    check("basic_latency", 32'(lat), N + 1);
    check("basic_mask", 32'(m), 32'b0001);
    check("basic_collision", 32'(c), 1);
    check("basic_busy_in_done", 32'(b), 1);
    check("after_done_pulse", 32'(done), 0);
    check("after_done_busy", 32'(busy), 0);
    check("held_mask", 32'(hit_mask), 32'b0001);

    // Edge touches: right edge x and bottom edge y exactly meet.
    enemy_valid = 4'b0010;
    set_enemy(1, 180, 321);
    frame(lat, m, c, b);
    check("touch_mask", 32'(m), 32'b0010);
    set_enemy(1, 181, 200);
    frame(lat, m, c, b);
    check("past_x_mask", 32'(m), 0);
    check("past_x_collision", 32'(c), 0);
    set_enemy(1, 180, 322);
    frame(lat, m, c, b);
    check("past_y_mask", 32'(m), 0);

    // Far corner: no alias from wrapped sums.
    car_x = 0; car_y = 0;
    enemy_valid = 4'b0100;
    set_enemy(2, 1000, 1000);
    frame(lat, m, c, b);
    check("wrap_far_mask", 32'(m), 0);
    car_x = 1000; car_y = 1000;
    set_enemy(2, 990, 990);
    frame(lat, m, c, b);
    check("wrap_near_mask", 32'(m), 32'b0100);
    enemy_valid = 4'b0000;
    frame(lat, m, c, b);
    check("invalid_mask", 32'(m), 0);
    check("invalid_collision", 32'(c), 0);

    // Several enemies, one invalid but overlapping.
    car_x = 100; car_y = 200;
    set_enemy(0, 150, 250); set_enemy(1, 500, 500); set_enemy(2, 20, 100); set_enemy(3, 100, 200);
    enemy_valid = 4'b0111;
    frame(lat, m, c, b);
    check("multi_mask", 32'(m), 32'b0101);
    check("multi_collision", 32'(c), 1);

    // Mid-scan start pulse and input changes must not affect the result.
    enemy_valid = 4'b0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    car_x = 600; enemy_valid = 4'b1111;
    set_enemy(3, 600, 200);
    @(negedge clk);
    start = 1'b0;
    lat = 3;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("snap_latency", 32'(lat), N + 1);
    check("snap_mask", 32'(hit_mask), 32'b0001);
    seen_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    check("start_not_queued", 32'(seen_done), 0);

    // Reset in the middle of a scan after a colliding result is held.
    car_x = 100; car_y = 200;
    set_enemy(0, 150, 250); enemy_valid = 4'b0001;
    frame(lat, m, c, b);
    check("pre_rst_mask", 32'(hit_mask), 32'b0001);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_mask", 32'(hit_mask), 0);
    check("rst_collision", 32'(collision), 0);
    seen_done = 0;
    repeat (8) begin
      if (done) seen_done++;
      @(negedge clk);
    end
    check("rst_no_done", 32'(seen_done), 0);

`ifdef COLLISION_COUNT_EN
    check("count_reset", 32'(hit_count), 0);
    for (int i = 0; i < 300; i++) begin
      frame(lat, m, c, b);
      if (i == 2) check("count_three", 32'(hit_count), 3);
    end
    check("count_saturate", 32'(hit_count), 255);
    enemy_valid = 4'b0000;
    frame(lat, m, c, b);
    check("count_no_hit_frame", 32'(c), 0);
    check("count_hold", 32'(hit_count), 255);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
